// File: rtl/lookup_cfg_ctrl_pkg.sv
// lookup_cfg_ctrl_pkg: shared widths, delete key and FSM encoding for the lookup-stage table updater.
// Used by the update controller, the control-channel parser and verification.
package lookup_cfg_ctrl_pkg;

    localparam int KEY_LEN = 197;
    localparam int ACT_LEN = 625;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int BUSY_TO = 64;

    // Reserved key the key extractor never produces, so a deleted entry can never hit.
    localparam logic [KEY_LEN-1:0] DEL_KEY = {KEY_LEN{1'b1}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        ACT_WR   = 3'd2,
        CAM_WR   = 3'd3,
        CAM_WAIT = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

endpackage

// File: rtl/lookup_cfg_ctrl_if.sv
// lookup_cfg_ctrl_if: control-channel update request (valid/ready plus entry fields).
// master = control parser (drives request), slave = lookup_cfg_ctrl (drives cfg_ready).
//   cfg_valid/cfg_ready : handshake
//   cfg_del             : 1 = delete, 0 = install
//   cfg_addr            : entry index
//   cfg_key/cfg_mask    : match key and ternary mask (1 = don't care)
//   cfg_act             : action word
interface lookup_cfg_ctrl_if;
    import lookup_cfg_ctrl_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_del;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [KEY_LEN-1:0] cfg_key;
    logic [KEY_LEN-1:0] cfg_mask;
    logic [ACT_LEN-1:0] cfg_act;

    modport master (
        output cfg_valid, cfg_del, cfg_addr, cfg_key, cfg_mask, cfg_act,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_del, cfg_addr, cfg_key, cfg_mask, cfg_act,
        output cfg_ready
    );

endinterface

// File: rtl/lookup_cfg_ctrl.sv
// lookup_cfg_ctrl: sequences one table update (quiesce, action write, CAM write, busy wait) into a lookup stage.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_if (slave)      : update request channel; cfg_ready high only in IDLE
//   i_key_valid         : datapath key strobe into the lookup stage
//   i_lkp_idle          : lookup FSM is idle
//   o_lkp_hold          : stall upstream key issue while an update is in flight
//   o_act_we/addr/din   : action RAM write port
//   o_cam_we/wr_addr/din/data_mask, i_cam_busy : CAM write port
//   o_entry_valid       : per-entry valid bitmap
//   o_cfg_done/o_cfg_err: one-cycle completion / failure pulses
module lookup_cfg_ctrl
    import lookup_cfg_ctrl_pkg::*;
#(
    parameter int DEPTH = lookup_cfg_ctrl_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    lookup_cfg_ctrl_if.slave    cfg_if,
    input  logic                i_key_valid,
    input  logic                i_lkp_idle,
    output logic                o_lkp_hold,
    output logic                o_act_we,
    output logic [ADDR_W-1:0]   o_act_addr,
    output logic [ACT_LEN-1:0]  o_act_din,
    output logic                o_cam_we,
    output logic [ADDR_W-1:0]   o_cam_wr_addr,
    output logic [KEY_LEN-1:0]  o_cam_din,
    output logic [KEY_LEN-1:0]  o_cam_data_mask,
    input  logic                i_cam_busy,
    output logic [DEPTH-1:0]    o_entry_valid,
    output logic                o_cfg_done,
    output logic                o_cfg_err
);

    localparam int CNT_W = $clog2(BUSY_TO);

    state_t             r_state;
    state_t             w_next;
    logic               r_ready;
    logic               r_del;
    logic [ADDR_W-1:0]  r_addr;
    logic [KEY_LEN-1:0] r_key;
    logic [KEY_LEN-1:0] r_mask;
    logic [ACT_LEN-1:0] r_act;
    logic [CNT_W-1:0]   r_cnt;
    logic [DEPTH-1:0]   r_valid;
    logic               w_cap;
    logic               w_new_ok;
    logic               w_in_range;

    assign w_cap      = cfg_if.cfg_valid && r_ready;
    assign w_new_ok   = 32'(cfg_if.cfg_addr) < DEPTH;
    assign w_in_range = 32'(r_addr) < DEPTH;

    assign cfg_if.cfg_ready = r_ready;
    assign o_entry_valid    = r_valid;

    always_comb begin
        w_next          = r_state;
        o_lkp_hold      = 1'b0;
        o_act_we        = 1'b0;
        o_act_addr      = '0;
        o_act_din       = '0;
        o_cam_we        = 1'b0;
        o_cam_wr_addr   = '0;
        o_cam_din       = '0;
        o_cam_data_mask = '0;
        o_cfg_done      = 1'b0;
        o_cfg_err       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cap) w_next = w_new_ok ? DRAIN : ERR;
            end
            DRAIN: begin
                o_lkp_hold = 1'b1;
                // a key strobed in this cycle is still in flight, so wait for a quiet idle cycle
                if (i_lkp_idle && !i_key_valid) w_next = r_del ? CAM_WR : ACT_WR;
            end
            ACT_WR: begin
                o_lkp_hold = 1'b1;
                o_act_we   = 1'b1;
                o_act_addr = r_addr;
                o_act_din  = r_act;
                w_next     = CAM_WR;
            end
            CAM_WR: begin
                o_lkp_hold      = 1'b1;
                o_cam_we        = 1'b1;
                o_cam_wr_addr   = r_addr;
                o_cam_din       = r_del ? DEL_KEY : r_key;
                o_cam_data_mask = r_del ? '0 : r_mask;
                w_next          = CAM_WAIT;
            end
            CAM_WAIT: begin
                o_lkp_hold = 1'b1;
                if (!i_cam_busy) w_next = DONE;
                else if (r_cnt == CNT_W'(BUSY_TO - 1)) w_next = ERR;
            end
            DONE: begin
                o_lkp_hold = 1'b1;
                o_cfg_done = 1'b1;
                w_next     = IDLE;
            end
            ERR: begin
                // a bad address never quiesced the datapath, so it must not stall it either
                o_lkp_hold = w_in_range;
                o_cfg_err  = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_del   <= 1'b0;
            r_addr  <= '0;
            r_key   <= '0;
            r_mask  <= '0;
            r_act   <= '0;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE);
            if (w_cap) begin
                r_del  <= cfg_if.cfg_del;
                r_addr <= cfg_if.cfg_addr;
                r_key  <= cfg_if.cfg_key;
                r_mask <= cfg_if.cfg_mask;
                r_act  <= cfg_if.cfg_act;
            end
            r_cnt <= (r_state == CAM_WAIT) ? r_cnt + 1'b1 : '0;
            if (r_state == DONE) r_valid[r_addr] <= !r_del;
            else if (r_state == ERR && w_in_range) r_valid[r_addr] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lookup_cfg_ctrl.sv
// tb_lookup_cfg_ctrl: directed bench for lookup_cfg_ctrl (default depth and a 12-entry build).
module tb_lookup_cfg_ctrl;
    import lookup_cfg_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic key_valid, lkp_idle, cam_busy;

    logic               hold, act_we, cam_we, done, err;
    logic [ADDR_W-1:0]  act_addr, cam_addr;
    logic [ACT_LEN-1:0] act_din;
    logic [KEY_LEN-1:0] cam_din, cam_mask;
    logic [15:0]        ev;

    logic               hold12, act_we12, cam_we12, done12, err12;
    logic [ADDR_W-1:0]  act_addr12, cam_addr12;
    logic [ACT_LEN-1:0] act_din12;
    logic [KEY_LEN-1:0] cam_din12, cam_mask12;
    logic [11:0]        ev12;

    int n_chk = 0;
    int n_pass = 0;
    int n_early;

    lookup_cfg_ctrl_if cfg_if();
    lookup_cfg_ctrl_if cfg12();

    lookup_cfg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_if(cfg_if),
        .i_key_valid(key_valid), .i_lkp_idle(lkp_idle), .o_lkp_hold(hold),
        .o_act_we(act_we), .o_act_addr(act_addr), .o_act_din(act_din),
        .o_cam_we(cam_we), .o_cam_wr_addr(cam_addr), .o_cam_din(cam_din),
        .o_cam_data_mask(cam_mask), .i_cam_busy(cam_busy),
        .o_entry_valid(ev), .o_cfg_done(done), .o_cfg_err(err)
    );

    lookup_cfg_ctrl #(.DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .cfg_if(cfg12),
        .i_key_valid(key_valid), .i_lkp_idle(lkp_idle), .o_lkp_hold(hold12),
        .o_act_we(act_we12), .o_act_addr(act_addr12), .o_act_din(act_din12),
        .o_cam_we(cam_we12), .o_cam_wr_addr(cam_addr12), .o_cam_din(cam_din12),
        .o_cam_data_mask(cam_mask12), .i_cam_busy(cam_busy),
        .o_entry_valid(ev12), .o_cfg_done(done12), .o_cfg_err(err12)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present one request; returns in the first cycle after the capture edge.
    task automatic send(input logic del, input logic [ADDR_W-1:0] addr,
                        input logic [KEY_LEN-1:0] key, input logic [KEY_LEN-1:0] mask,
                        input logic [ACT_LEN-1:0] act);
        cfg_if.cfg_del   = del;
        cfg_if.cfg_addr  = addr;
        cfg_if.cfg_key   = key;
        cfg_if.cfg_mask  = mask;
        cfg_if.cfg_act   = act;
        cfg_if.cfg_valid = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        logic [KEY_LEN-1:0] ones;
        ones = '1;
        rst_n = 1'b0;
        key_valid = 1'b0;
        lkp_idle = 1'b1;
        cam_busy = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_del = 1'b0; cfg_if.cfg_addr = '0;
        cfg_if.cfg_key = '0; cfg_if.cfg_mask = '0; cfg_if.cfg_act = '0;
        cfg12.cfg_valid = 1'b0; cfg12.cfg_del = 1'b0; cfg12.cfg_addr = '0;
        cfg12.cfg_key = '0; cfg12.cfg_mask = '0; cfg12.cfg_act = '0;
        tick();
        tick();
        check("rst_ready", cfg_if.cfg_ready, 0);
        check("rst_hold", hold, 0);
        check("rst_outs", {act_we, cam_we, done, err}, 0);
        check("rst_ev", ev, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", cfg_if.cfg_ready, 1);

        // 1: install addr 3
        send(1'b0, 4'd3, 197'h1A5, '0, 625'h3f);
        check("t1_ready_drop", cfg_if.cfg_ready, 0);
        check("t1_hold", hold, 1);
        check("t1_drain_we", {act_we, cam_we}, 0);
        tick();
        check("t1_act_we", {act_we, cam_we}, 2'b10);
        check("t1_act_addr", act_addr, 3);
        check("t1_act_din", act_din, 625'h3f);
        tick();
        check("t1_cam_we", {act_we, cam_we}, 2'b01);
        check("t1_cam_addr", cam_addr, 3);
        check("t1_cam_din", cam_din, 197'h1A5);
        check("t1_cam_mask", cam_mask, 0);
        tick();
        check("t1_wait", {done, err}, 0);
        tick();
        check("t1_done", {done, err, hold}, 3'b101);
        tick();
        check("t1_after", {done, hold, cfg_if.cfg_ready}, 3'b001);
        check("t1_ev", ev, 16'h0008);

        // 2: lookup busy, key strobed in the hold cycle
        lkp_idle = 1'b0;
        send(1'b0, 4'd5, 197'h55, 197'hF, 625'h123);
        key_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_busy", {hold, act_we}, 2'b10);
            key_valid = 1'b0;
            tick();
        end
        lkp_idle = 1'b1;
        key_valid = 1'b1;
        check("t2_hold_kv", {hold, act_we}, 2'b10);
        tick();
        check("t2_kv_blocks", {hold, act_we}, 2'b10);
        key_valid = 1'b0;
        tick();
        check("t2_act_we", {hold, act_we}, 2'b11);
        check("t2_act_addr", act_addr, 5);
        check("t2_act_din", act_din, 625'h123);
        tick();
        check("t2_cam_we", cam_we, 1);
        check("t2_cam_mask", cam_mask, 197'hF);
        tick();
        tick();
        check("t2_done", done, 1);
        tick();
        check("t2_ev", ev, 16'h0028);

        // 3: delete addr 3
        send(1'b1, 4'd3, 197'h1A5, 197'h7, 625'h3f);
        check("t3_drain", {hold, act_we, cam_we}, 3'b100);
        tick();
        check("t3_cam_we", {act_we, cam_we}, 2'b01);
        check("t3_cam_din", cam_din, ones);
        check("t3_cam_mask", cam_mask, 0);
        check("t3_cam_addr", cam_addr, 3);
        tick();
        check("t3_wait", {done, act_we}, 0);
        tick();
        check("t3_done", done, 1);
        tick();
        check("t3_ev", ev, 16'h0020);

        // 4: CAM busy timeout on valid entry 5
        cam_busy = 1'b1;
        send(1'b0, 4'd5, 197'h99, '0, 625'h1);
        tick();
        tick();
        tick();
        n_early = 0;
        for (int i = 0; i < BUSY_TO; i++) begin
            if (done || err) n_early++;
            tick();
        end
        check("t4_no_early", n_early, 0);
        check("t4_err", {err, done, hold}, 3'b101);
        tick();
        cam_busy = 1'b0;
        check("t4_after", {err, hold, cfg_if.cfg_ready}, 3'b001);
        check("t4_ev", ev, 0);

        // 5: out-of-range address on the 12-entry build
        cfg12.cfg_addr = 4'd13;
        cfg12.cfg_valid = 1'b1;
        tick();
        cfg12.cfg_valid = 1'b0;
        check("t5_err", {err12, done12}, 2'b10);
        check("t5_no_write", {hold12, act_we12, cam_we12}, 0);
        tick();
        check("t5_after", {err12, hold12, cfg12.cfg_ready}, 3'b001);
        check("t5_ev", ev12, 0);

        // 6: reset during CAM_WAIT, then a fresh install
        send(1'b0, 4'd4, 197'h4, '0, 625'h4);
        for (int i = 0; i < 5; i++) tick();
        check("t6_pre_ev", ev, 16'h0010);
        cam_busy = 1'b1;
        send(1'b0, 4'd2, 197'h2, '0, 625'h2);
        tick();
        tick();
        tick();
        check("t6_in_wait", {hold, done, err}, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async", {hold, cam_we, cfg_if.cfg_ready}, 0);
        check("t6_ev_clr", ev, 0);
        rst_n = 1'b1;
        cam_busy = 1'b0;
        tick();
        check("t6_ready", cfg_if.cfg_ready, 1);
        send(1'b0, 4'd9, 197'h9, '0, 625'h9);
        tick();
        tick();
        tick();
        check("t6_not_yet", done, 0);
        tick();
        check("t6_done", done, 1);
        tick();
        check("t6_ev", ev, 16'h0200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
